// File: rtl/bp_resolve_queue.sv
// In-order queue of predictor snapshots for branches in flight. Pops the oldest entry on
// resolve, produces the registered saturating-counter update and flags mispredicts with a redirect.
module bp_resolve_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic [31:0]      pred_target,
  input  logic [4:0]       pred_bhrt_index,
  input  logic [5:0]       pred_bhr,
  input  logic [1:0]       pred_state,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             upd_valid,
  output logic [4:0]       upd_bhrt_index,
  output logic [5:0]       upd_bhr,
  output logic [1:0]       upd_state,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             proto_err
);

  // Snapshot storage is data only; validity is tracked purely by the pointers and count.
  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_tgt   [DEPTH];
  logic [4:0]       r_idx   [DEPTH];
  logic [5:0]       r_bhr   [DEPTH];
  logic [1:0]       r_state [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_pop;
  logic             w_push;
  logic             w_fetch_ok;
  logic             w_mis;
  logic             w_proto;
  logic             w_head_taken;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_tgt;
  logic [1:0]       w_head_state;

  function automatic logic [1:0] sat_next(input logic [1:0] st, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (st == 2'b11) ? 2'b11 : st + 2'b01;
    else       nxt = (st == 2'b00) ? 2'b00 : st - 2'b01;
    return nxt;
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_head_pc    = r_pc[r_rd_ptr];
  assign w_head_tgt   = r_tgt[r_rd_ptr];
  assign w_head_state = r_state[r_rd_ptr];
  assign w_head_taken = w_head_state[1];

  assign w_pop = res_valid && !empty;
  assign w_mis = w_pop && ((w_head_taken != res_taken) ||
                           (res_taken && w_head_taken && (res_target != w_head_tgt)));

  // Fetch is wrong-path both on the squashing edge and while the redirect pulse is out.
  assign w_fetch_ok = pred_valid && !mispredict && !w_mis;
  assign w_push     = w_fetch_ok && (!full || w_pop);
  assign w_proto    = (pred_valid && !mispredict && full && !w_pop) || (res_valid && empty);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= pred_pc;
      r_tgt[r_wr_ptr]   <= pred_target;
      r_idx[r_wr_ptr]   <= pred_bhrt_index;
      r_bhr[r_wr_ptr]   <= pred_bhr;
      r_state[r_wr_ptr] <= pred_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      upd_valid      <= 1'b0;
      upd_bhrt_index <= '0;
      upd_bhr        <= '0;
      upd_state      <= '0;
      upd_taken      <= 1'b0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      proto_err      <= 1'b0;
    end else begin
      upd_valid  <= w_pop;
      mispredict <= w_mis;
      if (w_pop) begin
        upd_bhrt_index <= r_idx[r_rd_ptr];
        upd_bhr        <= r_bhr[r_rd_ptr];
        upd_state      <= sat_next(w_head_state, res_taken);
        upd_taken      <= res_taken;
      end
      if (w_mis)
        redirect_pc <= res_taken ? res_target : seq_pc(w_head_pc);
      if (w_proto)
        proto_err <= 1'b1;
      // A mispredict kills every younger entry; the same-cycle push was already suppressed.
      if (w_mis) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: a per-cycle vector table plus hand-written
// sequences for fill/wrap, squash and asynchronous reset.
module tb_bp_resolve_queue;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic [4:0]  pred_bhrt_index;
  logic [5:0]  pred_bhr;
  logic [1:0]  pred_state;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        upd_valid;
  logic [4:0]  upd_bhrt_index;
  logic [5:0]  upd_bhr;
  logic [1:0]  upd_state;
  logic        upd_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  bp_resolve_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
    .pred_bhrt_index(pred_bhrt_index), .pred_bhr(pred_bhr), .pred_state(pred_state),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .full(full), .empty(empty), .count(count),
    .upd_valid(upd_valid), .upd_bhrt_index(upd_bhrt_index), .upd_bhr(upd_bhr),
    .upd_state(upd_state), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] ptgt;
    logic [1:0]  pst;
    logic [5:0]  pbhr;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        uv;
    logic [1:0]  ust;
    logic        utk;
    logic [4:0]  uidx;
    logic [5:0]  ubhr;
    logic        mis;
    logic [31:0] rpc;
    int          cnt;
    logic        perr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(logic pv, logic [31:0] ppc, logic [31:0] ptgt, logic [1:0] pst,
                               logic [5:0] pbhr, logic rv, logic rt, logic [31:0] rtgt,
                               logic uv, logic [1:0] ust, logic utk, logic [4:0] uidx,
                               logic [5:0] ubhr, logic mis, logic [31:0] rpc, int cnt,
                               logic perr);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.ptgt = ptgt; v.pst = pst; v.pbhr = pbhr;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.uv = uv; v.ust = ust; v.utk = utk; v.uidx = uidx; v.ubhr = ubhr;
    v.mis = mis; v.rpc = rpc; v.cnt = cnt; v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic [1:0] pst, input logic [5:0] pbhr,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    pred_valid      = pv;
    pred_pc         = ppc;
    pred_target     = ptgt;
    pred_state      = pst;
    pred_bhr        = pbhr;
    pred_bhrt_index = ppc[6:2];
    res_valid       = rv;
    res_taken       = rt;
    res_target      = rtgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 2'b00, 6'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    step();
    rst = 1'b1;

    vecs[0]  = mkv(1, 'h40,  'h80,  2'b01, 6'h15, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h0,   1, 0);
    vecs[1]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 1, 'h80,  1, 2'b10, 1, 5'h10, 6'h15, 1, 'h80,  0, 0);
    vecs[2]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h80,  0, 0);
    vecs[3]  = mkv(1, 'h100, 'h180, 2'b11, 6'h2A, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h80,  1, 0);
    vecs[4]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 0, 'h0,   1, 2'b10, 0, 5'h00, 6'h2A, 1, 'h104, 0, 0);
    vecs[5]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h104, 0, 0);
    vecs[6]  = mkv(1, 'h200, 'h300, 2'b10, 6'h01, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h104, 1, 0);
    vecs[7]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 1, 'h308, 1, 2'b11, 1, 5'h00, 6'h01, 1, 'h308, 0, 0);
    vecs[8]  = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h308, 0, 0);
    vecs[9]  = mkv(1, 'h44,  'h90,  2'b11, 6'h3F, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h308, 1, 0);
    vecs[10] = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 1, 'h90,  1, 2'b11, 1, 5'h11, 6'h3F, 0, 'h308, 0, 0);
    vecs[11] = mkv(1, 'h48,  'h0,   2'b00, 6'h07, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h308, 1, 0);
    vecs[12] = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 0, 'h0,   1, 2'b00, 0, 5'h12, 6'h07, 0, 'h308, 0, 0);
    vecs[13] = mkv(1, 'h4C,  'h60,  2'b10, 6'h0B, 0, 0, 'h0,   0, 2'b00, 0, 5'h00, 6'h00, 0, 'h308, 1, 0);
    vecs[14] = mkv(1, 'h50,  'h70,  2'b01, 6'h0C, 1, 1, 'h60,  1, 2'b11, 1, 5'h13, 6'h0B, 0, 'h308, 1, 0);
    vecs[15] = mkv(0, 'h0,   'h0,   2'b00, 6'h00, 1, 0, 'h0,   1, 2'b00, 0, 5'h14, 6'h0C, 0, 'h308, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].ptgt, vecs[i].pst, vecs[i].pbhr,
            vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].uv));
      chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].mis));
      chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].rpc);
      chk($sformatf("v%0d_proto_err", i), 32'(proto_err), 32'(vecs[i].perr));
      if (vecs[i].uv) begin
        chk($sformatf("v%0d_upd_state", i), 32'(upd_state), 32'(vecs[i].ust));
        chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].utk));
        chk($sformatf("v%0d_upd_idx", i), 32'(upd_bhrt_index), 32'(vecs[i].uidx));
        chk($sformatf("v%0d_upd_bhr", i), 32'(upd_bhr), 32'(vecs[i].ubhr));
      end
    end

    // Fill to DEPTH, overflow push, then eight push+pop cycles that wrap both pointers.
    idle();
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + 32'(4*i), 32'h0, 2'b00, 6'(i), 1'b0, 1'b0, 32'h0);
      step();
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_proto_err", 32'(proto_err), 32'd0);
    drive(1'b1, 32'h1F00, 32'h0, 2'b00, 6'h3F, 1'b0, 1'b0, 32'h0);
    step();
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_proto_err", 32'(proto_err), 32'd1);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 32'h1020 + 32'(4*j), 32'h0, 2'b00, 6'(8+j), 1'b1, 1'b0, 32'h0);
      step();
      chk($sformatf("wrap%0d_upd_valid", j), 32'(upd_valid), 32'd1);
      chk($sformatf("wrap%0d_upd_state", j), 32'(upd_state), 32'd0);
      chk($sformatf("wrap%0d_mispredict", j), 32'(mispredict), 32'd0);
      chk($sformatf("wrap%0d_count", j), 32'(count), 32'd8);
      chk($sformatf("wrap%0d_upd_idx", j), 32'(upd_bhrt_index), 32'(j));
      chk($sformatf("wrap%0d_upd_bhr", j), 32'(upd_bhr), 32'(j));
    end
    idle();
    step();
    chk("wrap_idle_upd_valid", 32'(upd_valid), 32'd0);

    // Squash: three entries, head mispredicts with a concurrent push, next push ignored.
    do_reset();
    step();
    chk("sq_reset_proto_err", 32'(proto_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h2000 + 32'(4*i), 32'h0, 2'b00, 6'h00, 1'b0, 1'b0, 32'h0);
      step();
    end
    chk("sq_count3", 32'(count), 32'd3);
    drive(1'b1, 32'h200C, 32'h0, 2'b00, 6'h00, 1'b1, 1'b1, 32'h3000);
    step();
    chk("sq_count", 32'(count), 32'd0);
    chk("sq_empty", 32'(empty), 32'd1);
    chk("sq_mispredict", 32'(mispredict), 32'd1);
    chk("sq_redirect", redirect_pc, 32'h3000);
    chk("sq_upd_state", 32'(upd_state), 32'd1);
    drive(1'b1, 32'h2010, 32'h0, 2'b00, 6'h00, 1'b0, 1'b0, 32'h0);
    step();
    chk("sq_next_count", 32'(count), 32'd0);
    chk("sq_next_mispredict", 32'(mispredict), 32'd0);
    chk("sq_proto_err", 32'(proto_err), 32'd0);

    // Asynchronous reset with four entries and a pending update strobe.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h2100 + 32'(4*i), 32'h0, 2'b00, 6'h00, 1'b0, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 6'h00, 1'b1, 1'b0, 32'h0);
    step();
    chk("ar_pre_count", 32'(count), 32'd4);
    chk("ar_pre_upd_valid", 32'(upd_valid), 32'd1);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_upd_valid", 32'(upd_valid), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    #2 rst = 1'b1;

    // Resolve on an empty queue is ignored but flagged.
    drive(1'b0, 32'h0, 32'h0, 2'b00, 6'h00, 1'b1, 1'b1, 32'h4000);
    step();
    chk("emp_proto_err", 32'(proto_err), 32'd1);
    chk("emp_upd_valid", 32'(upd_valid), 32'd0);
    chk("emp_count", 32'(count), 32'd0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- Resolution-side counterpart of the local branch history predictor.
- Fetch pushes each predicted branch's predictor snapshot into an in-order queue: BHRT index, BHR, 2-bit counter state and predicted target.
- When the MEM stage resolves the oldest branch, the block pops the entry, computes the next saturating-counter state, and drives a registered update port back into the predictor.
- On a wrong prediction it raises mispredict with a redirect PC and squashes all younger queued entries.

Parameters:
- DEPTH, 8, queue entries; power of two, 2..32.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- pred_valid  in  1  fetch pushes a predicted branch
- pred_pc  in  32  branch PC
- pred_target  in  32  predicted taken target
- pred_bhrt_index  in  5  BHRT index used (PC[6:2])
- pred_bhr  in  6  history used to index the PHT
- pred_state  in  2  counter state read (00 sn, 01 wn, 10 wt, 11 st)
- res_valid  in  1  MEM resolves the oldest branch
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- full  out  1  DEPTH entries held
- empty  out  1  zero entries held
- count  out  PTR_W+1  occupancy
- upd_valid  out  1  one-cycle predictor write strobe
- upd_bhrt_index  out  5  entry to shift
- upd_bhr  out  6  PHT index to write
- upd_state  out  2  new counter state
- upd_taken  out  1  bit shifted into the BHR
- mispredict  out  1  one-cycle flush/redirect pulse
- redirect_pc  out  32  correct next PC
- proto_err  out  1  sticky: resolve on empty, or push on full without pop

Behaviour:
- Reset (rst low, async): pointers 0, count 0, empty 1, full 0; all upd_*, mispredict, proto_err 0; redirect_pc 0.
- Push: accepted when pred_valid && (!full || pop this cycle) && !mispredict. Push on full with no pop is dropped and sets proto_err.
- Pop: occurs when res_valid && !empty. Resolve on empty is ignored and sets proto_err.
- Head entry is readable combinationally. Simultaneous push+pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Prediction: predicted taken = pred_state[1].
- Mispredict condition: predicted direction != res_taken, OR (res_taken && predicted taken && res_target != stored target).
- Counter update (saturating, applied to the head state):
  - taken: sn->wn, wn->wt, wt->st, st->st
  - not taken: st->wt, wt->wn, wn->sn, sn->sn
- Output latency: all upd_* outputs, mispredict and redirect_pc register on the pop edge and are valid exactly one cycle later. upd_valid and mispredict are single-cycle pulses.
- redirect_pc = res_taken ? res_target : head pc + 4 (32-bit wrap). It holds its last value when mispredict is 0.
- Squash: on a mispredicting pop edge the queue empties (count 0, rd_ptr = wr_ptr). A push in that same cycle is discarded without setting proto_err. pred_valid is also ignored in the cycle mispredict is high (wrong-path fetch).
- Back-to-back resolves each produce one update per cycle, in order.
- Reset asserted mid-operation discards all entries and pending pulses immediately.

Test Plan:
- Push pc=0x40, state=01 (wn), target=0x80; resolve taken, target=0x80 -> next cycle upd_valid=1, upd_state=10, upd_taken=1, mispredict=1 (predicted not taken), redirect_pc=0x80, count=0.
- Push pc=0x100, state=11; resolve not taken -> upd_state=10, mispredict=1, redirect_pc=0x104.
- Push pc=0x200, state=10, target=0x300; resolve taken, target=0x308 -> mispredict=1 (target mismatch), upd_state=11, redirect_pc=0x308.
- Fill DEPTH=8 with correctly predicted states=00; push again without resolve -> dropped, proto_err=1, count=8. Then resolve eight times not taken with a simultaneous push each cycle -> count stays 8, eight consecutive upd_valid pulses with upd_state=00 and mispredict=0, and pointers wrap.
- Queue holds 3 entries; head mispredicts while pred_valid=1 -> count=0 after the edge, and the next-cycle push is ignored.
- Reset driven low between clock edges with 4 entries and a pending upd_valid -> count=0 and upd_valid=0 immediately, before any clock edge.
